// File: rtl/npu_requant_stream_out.sv
`default_nettype none
// ============================================================================
//  Module   : npu_requant_stream_out
//  Purpose  : Output stage after the systolic array. Accepts one vector of N
//             signed accumulators and requantizes every lane to INT8:
//             fixed-point multiply, rounding right shift, zero-point add and
//             saturation. The bytes then leave lane 0 first on an 8-bit
//             AXI-stream master. acc_last turns into tlast on the final byte.
//  Ports    : clk, rst (async, active-high)
//             acc_valid / acc_ready / acc_data / acc_last  - vector input
//             cfg_mult / cfg_shift / cfg_zp                - sampled on accept
//             m_tvalid / m_tready / m_tdata / m_tlast      - AXI-stream master
//  Revision : 1.0 - initial release
// ============================================================================
module npu_requant_stream_out #(
    parameter int N       = 4,
    parameter int ACC_W   = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_valid,
    output logic                 acc_ready,
    input  logic [N*ACC_W-1:0]   acc_data,
    input  logic                 acc_last,
    input  logic [MULT_W-1:0]    cfg_mult,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic [7:0]           cfg_zp,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tlast
);

    // Working width: the full product needs ACC_W+MULT_W+1 bits; one guard bit
    // on top keeps the rounding and zero-point additions from ever wrapping.
    localparam int c_PW = ACC_W + MULT_W + 2;
    localparam int c_LW = (N > 1) ? $clog2(N) : 1;

    localparam logic [c_LW-1:0]        c_LAST_LANE = c_LW'(N - 1);
    localparam logic [c_PW-1:0]        c_ONE       = {{(c_PW-1){1'b0}}, 1'b1};
    localparam logic signed [c_PW-1:0] c_SAT_MAX   = {{(c_PW-8){1'b0}}, 8'h7F};
    localparam logic signed [c_PW-1:0] c_SAT_MIN   = {{(c_PW-8){1'b1}}, 8'h80};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t                 r_state;
    logic [N*ACC_W-1:0]     r_acc;
    logic                   r_last;
    logic [MULT_W-1:0]      r_mult;
    logic [SHIFT_W-1:0]     r_shift;
    logic [7:0]             r_zp;
    logic [7:0]             r_bytes [N];
    logic [c_LW-1:0]        r_lane;

    logic [7:0]             w_bytes [N];
    logic [c_LW-1:0]        w_next_lane;

    // One lane: prod = acc * mult, round half toward +inf, add zp, saturate.
    function automatic logic [7:0] f_requant(
        input logic [ACC_W-1:0]   acc,
        input logic [MULT_W-1:0]  mult,
        input logic [SHIFT_W-1:0] shift,
        input logic [7:0]         zp
    );
        logic signed [c_PW-1:0] v_prod;
        logic signed [c_PW-1:0] v_half;
        logic signed [c_PW-1:0] v_r;
        logic signed [c_PW-1:0] v_s;
        v_prod = $signed({{(c_PW-ACC_W){acc[ACC_W-1]}}, acc}) *
                 $signed({{(c_PW-MULT_W){1'b0}}, mult});
        // 2^(shift-1), which collapses to zero when shift is zero
        v_half = $signed((c_ONE << shift) >> 1);
        v_r    = (v_prod + v_half) >>> shift;
        v_s    = v_r + $signed({{(c_PW-8){zp[7]}}, zp});
        if (v_s > c_SAT_MAX) begin
            f_requant = 8'h7F;
        end else if (v_s < c_SAT_MIN) begin
            f_requant = 8'h80;
        end else begin
            f_requant = v_s[7:0];
        end
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_bytes[i] = f_requant(r_acc[i*ACC_W +: ACC_W], r_mult, r_shift, r_zp);
        end
    end

    assign w_next_lane = r_lane + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            acc_ready <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tdata   <= 8'h00;
            m_tlast   <= 1'b0;
            r_lane    <= '0;
            r_acc     <= '0;
            r_last    <= 1'b0;
            r_mult    <= '0;
            r_shift   <= '0;
            r_zp      <= 8'h00;
            for (int i = 0; i < N; i++) begin
                r_bytes[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (acc_valid && acc_ready) begin
                        r_acc     <= acc_data;
                        r_last    <= acc_last;
                        r_mult    <= cfg_mult;
                        r_shift   <= cfg_shift;
                        r_zp      <= cfg_zp;
                        acc_ready <= 1'b0;
                        r_state   <= S_CALC;
                    end else begin
                        acc_ready <= 1'b1;
                    end
                end

                S_CALC: begin
                    for (int i = 0; i < N; i++) begin
                        r_bytes[i] <= w_bytes[i];
                    end
                    m_tdata  <= w_bytes[0];
                    // N >= 2, so lane 0 is never the final byte of a vector
                    m_tlast  <= 1'b0;
                    m_tvalid <= 1'b1;
                    r_lane   <= '0;
                    r_state  <= S_SEND;
                end

                S_SEND: begin
                    if (m_tready) begin
                        if (r_lane == c_LAST_LANE) begin
                            m_tvalid  <= 1'b0;
                            m_tlast   <= 1'b0;
                            acc_ready <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_lane  <= w_next_lane;
                            m_tdata <= r_bytes[w_next_lane];
                            m_tlast <= (w_next_lane == c_LAST_LANE) && r_last;
                        end
                    end
                end

                default: begin
                    acc_ready <= 1'b0;
                    m_tvalid  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npu_requant_stream_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_npu_requant_stream_out
//  Purpose  : Directed self-checking bench for npu_requant_stream_out with
//             hand-computed expected bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_npu_requant_stream_out;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          acc_valid = 1'b0;
    logic          acc_ready;
    logic [127:0]  acc_data = '0;
    logic          acc_last = 1'b0;
    logic [15:0]   cfg_mult = '0;
    logic [4:0]    cfg_shift = '0;
    logic [7:0]    cfg_zp = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [7:0]    m_tdata;
    logic          m_tlast;

    int n_checks = 0;
    int n_fails  = 0;

    npu_requant_stream_out #(
        .N       (N),
        .ACC_W   (32),
        .MULT_W  (16),
        .SHIFT_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .acc_last  (acc_last),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Presents one vector, then scrambles every input after the accept edge
    // so captured values are the only ones that can reach the output.
    // Returns on the negedge where the first beat must be valid.
    task automatic send_vec(input logic [127:0] acc, input logic last,
                            input logic [15:0] mult, input logic [4:0] shift,
                            input logic [7:0] zp);
        int k;
        k = 0;
        while (!acc_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("acc_ready_wait", {31'd0, acc_ready}, 32'd1);
        acc_valid = 1'b1;
        acc_data  = acc;
        acc_last  = last;
        cfg_mult  = mult;
        cfg_shift = shift;
        cfg_zp    = zp;
        @(negedge clk);
        acc_valid = 1'b0;
        acc_data  = {4{32'h1234_5678}};
        acc_last  = ~last;
        cfg_mult  = 16'd1;
        cfg_shift = 5'd0;
        cfg_zp    = 8'h33;
        check("calc_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("calc_acc_ready", {31'd0, acc_ready}, 32'd0);
        @(negedge clk);
        check("latency_tvalid", {31'd0, m_tvalid}, 32'd1);
    endtask

    // mode 0: tready held high. mode 1: low for 5 cycles on beat 0 then toggling.
    task automatic recv(input logic [31:0] exp_b, input logic exp_last, input int mode);
        int b;
        int c;
        logic rdy;
        b = 0;
        c = 0;
        while (b < N && c < 200) begin
            if (mode == 0) rdy = 1'b1;
            else           rdy = (c < 5) ? 1'b0 : (((c - 5) % 2) == 0);
            m_tready = rdy;
            check("tvalid", {31'd0, m_tvalid}, 32'd1);
            check("tdata", {24'd0, m_tdata}, {24'd0, exp_b[b*8 +: 8]});
            check("tlast", {31'd0, m_tlast}, {31'd0, exp_last && (b == N-1)});
            check("acc_ready_busy", {31'd0, acc_ready}, 32'd0);
            if (m_tvalid && rdy) b++;
            c++;
            @(negedge clk);
        end
        m_tready = 1'b0;
        check("beats_done", b, N);
        if (mode == 0) check("beats_back_to_back", c, N);
        check("post_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("post_acc_ready", {31'd0, acc_ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_acc_ready", {31'd0, acc_ready}, 32'd0);
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tdata", {24'd0, m_tdata}, 32'd0);
        check("rst_tlast", {31'd0, m_tlast}, 32'd0);
        rst = 1'b0;
        check("rel_acc_ready", {31'd0, acc_ready}, 32'd0);
        @(negedge clk);
        check("first_acc_ready", {31'd0, acc_ready}, 32'd1);

        // Nominal
        send_vec({32'd40, 32'd0, -32'd400, 32'd400}, 1'b0, 16'd16384, 5'd16, 8'hFB);
        recv(32'h05FB975F, 1'b0, 0);

        // Rounding, half toward +inf
        send_vec({-32'd5, 32'd5, -32'd6, 32'd6}, 1'b0, 16'd1, 5'd2, 8'h00);
        recv(32'hFF01FF02, 1'b0, 0);

        // Saturation at both rails plus exact rail values
        send_vec({-32'd128, 32'd127, 32'd100000, -32'd100000}, 1'b0, 16'd1, 5'd0, 8'h00);
        recv(32'h807F7F80, 1'b0, 0);

        // Backpressure with tlast, then a non-last follow-up vector
        send_vec({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, 16'd1, 5'd0, 8'd10);
        recv(32'h0E0D0C0B, 1'b1, 1);
        send_vec({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 16'd1, 5'd0, 8'd10);
        recv(32'h0E0D0C0B, 1'b0, 0);

        // Config isolation: cfg_mult goes to 1 right after the accept edge
        send_vec({32'd40, 32'd0, -32'd400, 32'd400}, 1'b0, 16'd16384, 5'd16, 8'hFB);
        check("iso_cfg_changed", {16'd0, cfg_mult}, 32'd1);
        recv(32'h05FB975F, 1'b0, 0);

        // Reset asserted while beat 2 is pending
        send_vec({32'd40, 32'd0, -32'd400, 32'd400}, 1'b1, 16'd16384, 5'd16, 8'hFB);
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_tready = 1'b0;
        check("mid_beat2_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("mid_beat2_tdata", {24'd0, m_tdata}, 32'h000000FB);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("mid_rst_acc_ready", {31'd0, acc_ready}, 32'd0);
        check("mid_rst_tlast", {31'd0, m_tlast}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rel_acc_ready", {31'd0, acc_ready}, 32'd0);
        @(negedge clk);
        check("mid_edge_acc_ready", {31'd0, acc_ready}, 32'd1);
        send_vec({-32'd5, 32'd5, -32'd6, 32'd6}, 1'b0, 16'd1, 5'd2, 8'h00);
        recv(32'hFF01FF02, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/npu_requant_stream_out.md
Name: npu_requant_stream_out

Overview:
- Output stage downstream of the systolic array.
- Each cycle-accepted item is one vector of N signed INT32 column accumulators. The block requantizes each lane to INT8 using a fixed-point multiply, a rounding right shift, a zero-point add and saturation.
- The resulting bytes are serialized lane 0 first onto an 8-bit AXI-stream master (npu_axi_stream_if, WIDTH=8, master modport) toward output DMA.
- acc_last marks the final vector of a tile and becomes tlast on that vector's last byte.

Parameters:
N, 4, number of accumulator lanes per vector (≥2)
ACC_W, 32, accumulator width per lane, signed
MULT_W, 16, requant multiplier width, unsigned
SHIFT_W, 5, requant shift width (shift range 0..31)

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  asynchronous, active-high reset
acc_valid  input  1  accumulator vector valid
acc_ready  output  1  block can accept a vector
acc_data  input  N*ACC_W  lane i at bits [i*ACC_W +: ACC_W], signed
acc_last  input  1  vector is last of tile
cfg_mult  input  MULT_W  multiplier, unsigned; sampled on vector accept
cfg_shift  input  SHIFT_W  right shift; sampled on vector accept
cfg_zp  input  8  output zero point, signed; sampled on vector accept
m_tvalid  output  1  AXI-stream valid
m_tready  input  1  AXI-stream ready
m_tdata  output  8  requantized INT8 byte, two's complement
m_tlast  output  1  last byte of tile

Behaviour:

Clock and reset:
- One clock domain (clk). rst is asynchronous and active-high.
- On rst: state=IDLE, acc_ready=0, m_tvalid=0, m_tdata=0, m_tlast=0, lane counter=0, all capture registers cleared.
- acc_ready is registered. It rises on the first clk edge after rst deasserts.
- rst asserted mid-operation aborts the vector in flight. No partial tile is resumed; the pending byte and tlast are dropped.

State machine (registered states IDLE, CALC, SEND):
- IDLE: acc_ready=1. On acc_valid&&acc_ready, register acc_data, acc_last, cfg_mult, cfg_shift and cfg_zp, drop acc_ready, and go to CALC.
- CALC (exactly one cycle): compute all N requantized bytes into a byte register array, set lane=0, and go to SEND.
- SEND: m_tvalid=1, m_tdata=byte[lane], m_tlast=(lane==N-1)&&last_reg.
  - On m_tvalid&&m_tready with lane<N-1: lane++.
  - On m_tvalid&&m_tready with lane==N-1: m_tvalid drops the next cycle and state returns to IDLE. acc_ready is 1 in that same next cycle.
- Config changes outside the accept cycle have no effect on a vector already captured.

Timing and throughput:
- Latency is 2 cycles from accept to first m_tvalid: the accept edge, then the CALC edge.
- With m_tready held at 1, each vector occupies N+2 cycles (IDLE accept, CALC, N SEND beats).
- acc_ready is never 1 outside IDLE. No vector overlap.

AXI-stream rules:
- m_tvalid never depends combinationally on m_tready.
- Once m_tvalid=1, m_tdata and m_tlast are held stable until the handshake. m_tvalid does not deassert before the handshake.
- Backpressure of any length is tolerated.

Arithmetic, per lane:
- prod = signed acc × zero-extended cfg_mult, computed at full width ACC_W+MULT_W+1 bits.
- If shift=0, r=prod. Otherwise r = (prod + 2^(shift-1)) >>> shift, an arithmetic shift (round half toward +inf).
- s = r + sign-extended cfg_zp.
- Saturate s to [-128,127]. Width must be sufficient that no intermediate step wraps.

Test Plan:
1. Nominal: N=4, mult=16384, shift=16, zp=-5, lanes {400,-400,0,40}, m_tready=1 -> bytes 95, -105(0x97), -5(0xFB), 5; m_tvalid first high 2 cycles after accept; 4 consecutive beats.
2. Rounding: mult=1, shift=2, zp=0, lanes {6,-6,5,-5} -> bytes 2, -1(0xFF), 1, -1(0xFF).
3. Saturation: mult=1, shift=0, zp=0, lanes {-100000, 100000, 127, -128} -> 0x80, 0x7F, 0x7F, 0x80.
4. Backpressure and tlast:
   - Stimulus: vector with acc_last=1; m_tready low for 5 cycles on beat 0 and toggling every cycle afterwards.
   - Required: m_tdata and m_tlast stable while stalled; m_tlast=1 only on beat 3; acc_ready=0 until the cycle after beat 3 is accepted.
   - Follow-up: next vector with acc_last=0 shows m_tlast=0 on all 4 beats.
5. Config isolation: change cfg_mult from 16384 to 1 the cycle after accept -> output still uses 16384.
6. Reset mid-send:
   - Stimulus: assert rst asynchronously while on beat 2.
   - Required: m_tvalid=0 and acc_ready=0 immediately; acc_ready=1 one edge after release; next vector starts at lane 0.
